// File: rtl/alu_writeback_pkg.sv
// Shared encodings for the alu_writeback block: writeback opcodes, FSM states,
// jump-offset width and the captured ALU flag record.
package alu_writeback_pkg;

  localparam int JT_W = 8;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_A    = 3'd1;
  localparam logic [2:0] WB_X    = 3'd2;
  localparam logic [2:0] WB_JEQ  = 3'd3;
  localparam logic [2:0] WB_JGT  = 3'd4;
  localparam logic [2:0] WB_JGE  = 3'd5;
  localparam logic [2:0] WB_JSET = 3'd6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef struct packed {
    logic set;
    logic eq;
    logic gt;
    logic ge;
  } flags_t;

  // Unknown opcodes collapse to WB_NONE so they retire without touching state.
  function automatic logic [2:0] wb_op_norm(input logic [2:0] op);
    return (op > WB_JSET) ? WB_NONE : op;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Controller command and ALU result handshakes feeding alu_writeback.
interface alu_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 10
);
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [2:0]            cmd_op;
  logic [PC_WIDTH-1:0]   cmd_pc;
  logic [7:0]            cmd_jt;
  logic [7:0]            cmd_jf;
  logic [DATA_WIDTH-1:0] ALU_out;
  logic                  set;
  logic                  eq;
  logic                  gt;
  logic                  ge;
  logic                  ALU_vld;
  logic                  ALU_ack;

  modport master (
    output cmd_vld, cmd_op, cmd_pc, cmd_jt, cmd_jf, ALU_out, set, eq, gt, ge, ALU_vld,
    input  cmd_rdy, ALU_ack
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_pc, cmd_jt, cmd_jf, ALU_out, set, eq, gt, ge, ALU_vld,
    output cmd_rdy, ALU_ack
  );
endinterface

// File: rtl/wb_jmp_calc.sv
// Conditional-jump resolver: picks jt/jf from the op's flag and forms pc+1+offset,
// reporting any carry past PC_WIDTH so the top can trap out-of-range targets.
module wb_jmp_calc
  import alu_writeback_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic [2:0]          op,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [JT_W-1:0]     jt,
  input  logic [JT_W-1:0]     jf,
  input  flags_t              flg,
  output logic                is_jmp,
  output logic [PC_WIDTH-1:0] target,
  output logic                carry
);
  localparam int SW = PC_WIDTH + JT_W + 1;

  logic          cond;
  logic [SW-1:0] sum;

  always_comb begin
    is_jmp = 1'b1;
    cond   = 1'b0;
    case (op)
      WB_JEQ:  cond = flg.eq;
      WB_JGT:  cond = flg.gt;
      WB_JGE:  cond = flg.ge;
      WB_JSET: cond = flg.set;
      default: is_jmp = 1'b0;
    endcase
  end

  assign sum    = SW'(pc) + SW'(1) + SW'(cond ? jt : jf);
  assign target = sum[PC_WIDTH-1:0];
  assign carry  = |sum[SW-1:PC_WIDTH];

endmodule

// File: rtl/alu_writeback.sv
// Holds one writeback command, waits for the ALU result, then retires it into A/X
// or resolves a conditional jump. Define ALU_WB_PC_TRAP_EN to add the pc_trap output.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_writeback_if.slave        bus,
  output logic [DATA_WIDTH-1:0] A_q,
  output logic [DATA_WIDTH-1:0] X_q,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_next,
`ifdef ALU_WB_PC_TRAP_EN
  output logic                  pc_trap,
`endif
  output logic                  wb_done
);
  logic [1:0]            state;
  logic [2:0]            op_q;
  logic [2:0]            op_in;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [JT_W-1:0]       jt_q;
  logic [JT_W-1:0]       jf_q;
  logic [DATA_WIDTH-1:0] res_q;
  flags_t                flg_q;
  logic                  is_jmp;
  logic                  carry;
  logic [PC_WIDTH-1:0]   target;

  // Ready is masked by reset so the controller never sees a stale accept window.
  assign bus.cmd_rdy = rst_n && (state == ST_IDLE);
  assign bus.ALU_ack = (state == ST_WAIT) && bus.ALU_vld;
  assign op_in       = wb_op_norm(bus.cmd_op);

  wb_jmp_calc #(.PC_WIDTH(PC_WIDTH)) u_jmp (
    .op     (op_q),
    .pc     (pc_q),
    .jt     (jt_q),
    .jf     (jf_q),
    .flg    (flg_q),
    .is_jmp (is_jmp),
    .target (target),
    .carry  (carry)
  );

`ifndef ALU_WB_PC_TRAP_EN
  logic unused_carry;
  assign unused_carry = carry;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= WB_NONE;
      pc_q    <= '0;
      jt_q    <= '0;
      jf_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      A_q     <= '0;
      X_q     <= '0;
      pc_load <= 1'b0;
      pc_next <= '0;
      wb_done <= 1'b0;
`ifdef ALU_WB_PC_TRAP_EN
      pc_trap <= 1'b0;
`endif
    end else begin
      pc_load <= 1'b0;
      wb_done <= 1'b0;
      case (state)
        ST_IDLE: if (bus.cmd_vld) begin
          op_q  <= op_in;
          pc_q  <= bus.cmd_pc;
          jt_q  <= bus.cmd_jt;
          jf_q  <= bus.cmd_jf;
          state <= (op_in == WB_NONE) ? ST_COMMIT : ST_WAIT;
        end
        ST_WAIT: if (bus.ALU_vld) begin
          res_q <= bus.ALU_out;
          flg_q <= '{set: bus.set, eq: bus.eq, gt: bus.gt, ge: bus.ge};
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state   <= ST_IDLE;
          wb_done <= 1'b1;
          if (op_q == WB_A) A_q <= res_q;
          if (op_q == WB_X) X_q <= res_q;
          if (is_jmp) begin
`ifdef ALU_WB_PC_TRAP_EN
            if (carry) begin
              pc_trap <= 1'b1;
            end else begin
              pc_load <= 1'b1;
              pc_next <= target;
            end
`else
            pc_load <= 1'b1;
            pc_next <= target;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Table-driven bench for alu_writeback with a scoreboard queue of expected retirements,
// plus hand sequences for stray ALU results and reset mid-command.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A_q, X_q;
  logic        pc_load, wb_done;
  logic [9:0]  pc_next;
`ifdef ALU_WB_PC_TRAP_EN
  logic        pc_trap;
`endif

  int checks = 0;
  int failures = 0;

  alu_writeback_if #(.DATA_WIDTH(32), .PC_WIDTH(10)) b ();

  alu_writeback #(.DATA_WIDTH(32), .PC_WIDTH(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (b),
    .A_q     (A_q),
    .X_q     (X_q),
    .pc_load (pc_load),
    .pc_next (pc_next),
`ifdef ALU_WB_PC_TRAP_EN
    .pc_trap (pc_trap),
`endif
    .wb_done (wb_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [9:0]  pc;
    logic [7:0]  jt, jf;
    logic [31:0] alu;
    logic [3:0]  flg;   // {set, eq, gt, ge}
    int          stall;
    logic [31:0] ea, ex;
    logic        el;
    logic [9:0]  epc;
  } vec_t;

  typedef struct {
    logic [31:0] a, x;
    logic        ld;
    logic [9:0]  pcn;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[11];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic needs_alu(logic [2:0] op);
    return (op >= WB_A) && (op <= WB_JSET);
  endfunction

  task automatic push_exp(vec_t v);
    exp_t e;
    e.a = v.ea; e.x = v.ex; e.ld = v.el; e.pcn = v.epc;
    sbq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic accept(vec_t v);
    int n = 0;
    b.cmd_vld = 1'b1;
    b.cmd_op  = v.op;
    b.cmd_pc  = v.pc;
    b.cmd_jt  = v.jt;
    b.cmd_jf  = v.jf;
    while (!b.cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_rdy_wait", {63'd0, b.cmd_rdy}, 64'd1);
    @(negedge clk);
    b.cmd_vld = 1'b0;
  endtask

  task automatic alu_phase(vec_t v);
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_ack", {63'd0, b.ALU_ack}, 64'd0);
      chk("stall_rdy", {63'd0, b.cmd_rdy}, 64'd0);
      @(negedge clk);
    end
    b.ALU_out = v.alu;
    {b.set, b.eq, b.gt, b.ge} = v.flg;
    b.ALU_vld = 1'b1;
    #1;
    chk("alu_ack", {63'd0, b.ALU_ack}, 64'd1);
    @(negedge clk);
    b.ALU_vld = 1'b0;
  endtask

  // Entered at the negedge inside the COMMIT cycle.
  task automatic finish_cmd(string nm);
    exp_t e;
    chk({nm, "_commit_done"}, {63'd0, wb_done}, 64'd0);
    chk({nm, "_commit_ack"}, {63'd0, b.ALU_ack}, 64'd0);
    @(negedge clk);
    chk({nm, "_wb_done"}, {63'd0, wb_done}, 64'd1);
    chk({nm, "_rdy_back"}, {63'd0, b.cmd_rdy}, 64'd1);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_A_q"}, {32'd0, A_q}, {32'd0, e.a});
      chk({nm, "_X_q"}, {32'd0, X_q}, {32'd0, e.x});
      chk({nm, "_pc_load"}, {63'd0, pc_load}, {63'd0, e.ld});
      chk({nm, "_pc_next"}, {54'd0, pc_next}, {54'd0, e.pcn});
    end
    @(negedge clk);
    chk({nm, "_done_pulse"}, {63'd0, wb_done}, 64'd0);
    chk({nm, "_load_pulse"}, {63'd0, pc_load}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            op       pc    jt     jf     alu           flg     st  ea            ex            el    epc
    vt[0]  = '{WB_A,    10'd5,    8'd0,  8'd0,   32'hDEADBEEF, 4'b0000, 0, 32'hDEADBEEF, 32'h0,        1'b0, 10'd0};
    vt[1]  = '{WB_JEQ,  10'd10,   8'd3,  8'd7,   32'h0,        4'b0100, 0, 32'hDEADBEEF, 32'h0,        1'b1, 10'd14};
    vt[2]  = '{WB_JEQ,  10'd10,   8'd3,  8'd7,   32'h0,        4'b1011, 1, 32'hDEADBEEF, 32'h0,        1'b1, 10'd18};
    vt[3]  = '{WB_X,    10'd20,   8'd0,  8'd0,   32'h12345678, 4'b1111, 6, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd18};
    vt[4]  = '{WB_JGT,  10'd100,  8'd20, 8'd1,   32'h0,        4'b0010, 0, 32'hDEADBEEF, 32'h12345678, 1'b1, 10'd121};
    vt[5]  = '{WB_JGE,  10'd200,  8'd5,  8'd255, 32'h0,        4'b1110, 2, 32'hDEADBEEF, 32'h12345678, 1'b1, 10'd456};
`ifdef ALU_WB_PC_TRAP_EN
    vt[6]  = '{WB_JSET, 10'd1023, 8'd0,  8'd9,   32'h0,        4'b1000, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd456};
    vt[7]  = '{WB_NONE, 10'd3,    8'd1,  8'd1,   32'h0,        4'b0000, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd456};
    vt[8]  = '{3'd7,    10'd4,    8'd1,  8'd1,   32'h0,        4'b1111, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd456};
`else
    vt[6]  = '{WB_JSET, 10'd1023, 8'd0,  8'd9,   32'h0,        4'b1000, 0, 32'hDEADBEEF, 32'h12345678, 1'b1, 10'd0};
    vt[7]  = '{WB_NONE, 10'd3,    8'd1,  8'd1,   32'h0,        4'b0000, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd0};
    vt[8]  = '{3'd7,    10'd4,    8'd1,  8'd1,   32'h0,        4'b1111, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 10'd0};
`endif
    vt[9]  = '{WB_JGT,  10'd0,    8'd1,  8'd2,   32'h0,        4'b0101, 0, 32'hDEADBEEF, 32'h12345678, 1'b1, 10'd3};
    vt[10] = '{WB_A,    10'd7,    8'd0,  8'd0,   32'h00000001, 4'b0000, 0, 32'h00000001, 32'h12345678, 1'b0, 10'd3};

    b.cmd_vld = 1'b0; b.cmd_op = '0; b.cmd_pc = '0; b.cmd_jt = '0; b.cmd_jf = '0;
    b.ALU_out = '0; b.set = 1'b0; b.eq = 1'b0; b.gt = 1'b0; b.ge = 1'b0; b.ALU_vld = 1'b0;

    #1;
    chk("rst_cmd_rdy", {63'd0, b.cmd_rdy}, 64'd0);
    chk("rst_ack", {63'd0, b.ALU_ack}, 64'd0);
    chk("rst_A", {32'd0, A_q}, 64'd0);
    chk("rst_X", {32'd0, X_q}, 64'd0);
    chk("rst_outs", {61'd0, pc_load, wb_done, |pc_next}, 64'd0);
`ifdef ALU_WB_PC_TRAP_EN
    chk("rst_trap", {63'd0, pc_trap}, 64'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {63'd0, b.cmd_rdy}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      v = vt[i];
      push_exp(v);
      accept(v);
      if (needs_alu(v.op)) alu_phase(v);
      finish_cmd($sformatf("vec%0d", i));
`ifdef ALU_WB_PC_TRAP_EN
      if (i == 6) chk("trap_set", {63'd0, pc_trap}, 64'd1);
`endif
    end
`ifdef ALU_WB_PC_TRAP_EN
    chk("trap_sticky", {63'd0, pc_trap}, 64'd1);
`endif

    // Stray ALU result in IDLE stays pending, then retires through a WB_X command.
    b.ALU_out = 32'hCAFEF00D;
    {b.set, b.eq, b.gt, b.ge} = 4'b0000;
    b.ALU_vld = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stray_ack", {63'd0, b.ALU_ack}, 64'd0);
      chk("stray_A", {32'd0, A_q}, 64'h1);
      chk("stray_X", {32'd0, X_q}, 64'h12345678);
      @(negedge clk);
    end
    v = '{WB_X, 10'd50, 8'd0, 8'd0, 32'hCAFEF00D, 4'b0000, 0,
          32'h00000001, 32'hCAFEF00D, 1'b0, 10'd3};
    push_exp(v);
    chk("stray_accept_ack", {63'd0, b.ALU_ack}, 64'd0);
    accept(v);
    #1;
    chk("stray_wait_ack", {63'd0, b.ALU_ack}, 64'd1);
    @(negedge clk);
    b.ALU_vld = 1'b0;
    finish_cmd("stray");

    // Reset while waiting on a valid ALU result.
    v = '{WB_A, 10'd60, 8'd0, 8'd0, 32'h55, 4'b0000, 0, 32'h55, 32'h0, 1'b0, 10'd0};
    accept(v);
    b.ALU_out = 32'h55;
    b.ALU_vld = 1'b1;
    #1;
    chk("rstmid_ack_before", {63'd0, b.ALU_ack}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack", {63'd0, b.ALU_ack}, 64'd0);
    chk("rstmid_done", {63'd0, wb_done}, 64'd0);
    chk("rstmid_A", {32'd0, A_q}, 64'd0);
    chk("rstmid_X", {32'd0, X_q}, 64'd0);
    chk("rstmid_rdy", {63'd0, b.cmd_rdy}, 64'd0);
`ifdef ALU_WB_PC_TRAP_EN
    chk("rstmid_trap", {63'd0, pc_trap}, 64'd0);
`endif
    b.ALU_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_rdy_after", {63'd0, b.cmd_rdy}, 64'd1);
    chk("rstmid_no_pulse", {62'd0, wb_done, pc_load}, 64'd0);
    chk("rstmid_pcn", {54'd0, pc_next}, 64'd0);
    chk("sb_drained", {32'd0, 32'(sbq.size())}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
